countdown_timer: RTL and testbench

- Down-counting timer: the decrementing counterpart of the team's up-counter.
- Counts a loaded value down toward a terminal value, then signals expiry.
- Supports one-shot and periodic (auto-reload) operation, plus start/stop/pause control.
- Sits beside the up-counter in timing/sequencing paths: timeouts, tick dividers, periodic strobes.

---
 rtl/countdown_timer_if.sv | 29 ++
 rtl/countdown_timer.sv | 98 +++++++++
 tb/tb_countdown_timer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/countdown_timer_if.sv
// Control and status bundle for countdown_timer: the sequencer drives the
// control strobes (master), the timer reports its count and status (slave).
interface countdown_timer_if #(
  parameter int DATA_WIDTH = 4
);
  // Control strobes are level-sampled on every rising clk edge; there is no
  // valid/ready pairing. Priority when several are high: load > stop > start > en.
  logic                  en;
  logic                  load;
  logic [DATA_WIDTH-1:0] loadval;
  logic                  start;
  logic                  stop;
  logic                  periodic;
  logic [DATA_WIDTH-1:0] dataOut;
  logic                  busy;
  logic                  done;
  logic                  expired;
  logic [1:0]            state;

  modport master (
    output en, load, loadval, start, stop, periodic,
    input  dataOut, busy, done, expired, state
  );

  modport slave (
    input  en, load, loadval, start, stop, periodic,
    output dataOut, busy, done, expired, state
  );
endinterface

// File: rtl/countdown_timer.sv
// Down-counting timer with one-shot / auto-reload modes and start/stop/pause
// control; every output, including the debug state, comes straight from a register.
module countdown_timer #(
  parameter int          DATA_WIDTH = 4,
  parameter int unsigned COUNT_END  = 0,
  parameter int unsigned STEP       = 1
) (
  input logic          clk,
  input logic          rst,
  countdown_timer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  localparam logic [DATA_WIDTH-1:0] END_VAL  = DATA_WIDTH'(COUNT_END);
  localparam logic [DATA_WIDTH-1:0] STEP_VAL = DATA_WIDTH'(STEP);
  // One extra bit so COUNT_END+STEP cannot overflow the comparison.
  localparam logic [DATA_WIDTH:0]   TERM_LIMIT =
    (DATA_WIDTH+1)'(COUNT_END) + (DATA_WIDTH+1)'(STEP);

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_count;
  logic [DATA_WIDTH-1:0] r_reload;
  logic                  r_done;
  logic                  r_busy;
  logic                  r_expired;

  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] w_count_nxt;
  logic [DATA_WIDTH-1:0] w_reload_nxt;
  logic                  w_done_nxt;
  logic                  w_terminal;

  assign w_terminal = ({1'b0, r_count} <= TERM_LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_reload  <= '0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_reload  <= w_reload_nxt;
      r_done    <= w_done_nxt;
      r_busy    <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_PAUSE);
      r_expired <= (w_state_nxt == ST_EXPIRED);
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_reload_nxt = r_reload;
    w_done_nxt   = 1'b0;
    if (bus.load) begin
      w_count_nxt  = bus.loadval;
      w_reload_nxt = bus.loadval;
      w_state_nxt  = ST_IDLE;
    end else if (bus.stop) begin
      // A stop consumes the cycle even outside RUN, so it always beats start.
      if (r_state == ST_RUN) begin
        w_state_nxt = ST_PAUSE;
      end
    end else if (bus.start && (r_state != ST_RUN)) begin
      w_state_nxt = ST_RUN;
      if (r_state == ST_EXPIRED) begin
        w_count_nxt = r_reload;
      end
    end else if ((r_state == ST_RUN) && bus.en) begin
      if (!w_terminal) begin
        w_count_nxt = r_count - STEP_VAL;
      end else if (bus.periodic) begin
        w_count_nxt = r_reload;
        w_done_nxt  = 1'b1;
      end else begin
        w_count_nxt = END_VAL;
        w_state_nxt = ST_EXPIRED;
        w_done_nxt  = 1'b1;
      end
    end
  end

  assign bus.dataOut = r_count;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.expired = r_expired;
  assign bus.state   = r_state;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: a default instance (COUNT_END=0, STEP=1)
// and a second instance with COUNT_END=1, STEP=2, sharing one set of controls.
module tb_countdown_timer;

  localparam int DW = 4;
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2, S_EXP = 2'd3;

  logic          clk;
  logic          rst;
  logic          en, load, start, stop, periodic;
  logic [DW-1:0] loadval;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_v;

  countdown_timer_if #(.DATA_WIDTH(DW)) if0 ();
  countdown_timer_if #(.DATA_WIDTH(DW)) if1 ();

  assign if0.en = en;             assign if1.en = en;
  assign if0.load = load;         assign if1.load = load;
  assign if0.loadval = loadval;   assign if1.loadval = loadval;
  assign if0.start = start;       assign if1.start = start;
  assign if0.stop = stop;         assign if1.stop = stop;
  assign if0.periodic = periodic; assign if1.periodic = periodic;

  countdown_timer #(.DATA_WIDTH(DW), .COUNT_END(0), .STEP(1)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  countdown_timer #(.DATA_WIDTH(DW), .COUNT_END(1), .STEP(2)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctrl(input logic l, input logic [DW-1:0] lv, input logic st,
                          input logic sp, input logic e, input logic p);
    load = l; loadval = lv; start = st; stop = sp; en = e; periodic = p;
  endtask

  // Scoreboard comparison
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    logic en_pat  [8];
    logic [DW-1:0] cnt_pat [8];
    logic done_pat[8];
    en_pat   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    cnt_pat  = '{4'd6, 4'd6, 4'd4, 4'd4, 4'd2, 4'd2, 4'd1, 4'd1};
    done_pat = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    rst = 1'b0;
    set_ctrl(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    check("rst_count",   if0.dataOut, 0);
    check("rst_busy",    if0.busy,    0);
    check("rst_done",    if0.done,    0);
    check("rst_expired", if0.expired, 0);
    check("rst_state",   if0.state,   S_IDLE);
    #1 rst = 1'b1;

    // One-shot: load 5, start, count to 0
    set_ctrl(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("os_load_count", if0.dataOut, 5);
    check("os_load_state", if0.state, S_IDLE);
    set_ctrl(1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("os_start_count", if0.dataOut, 5);
    check("os_start_busy", if0.busy, 1);
    set_ctrl(1'b0, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int v = 4; v >= 0; v--) exp_q.push_back(DW'(v));
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      tick();
      check("os_count", if0.dataOut, exp_v);
      check("os_done", if0.done, (exp_v == 0));
    end
    check("os_expired", if0.expired, 1);
    check("os_busy", if0.busy, 0);
    tick();
    check("os_hold_count", if0.dataOut, 0);
    check("os_hold_done", if0.done, 0);
    set_ctrl(1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("os_restart_count", if0.dataOut, 5);
    check("os_restart_state", if0.state, S_RUN);
    check("os_restart_expired", if0.expired, 0);

    // Periodic: load 3 -> 2,1,3,2,1,3
    set_ctrl(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    set_ctrl(1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    check("per_start_count", if0.dataOut, 3);
    set_ctrl(1'b0, 4'd3, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(4'd2); exp_q.push_back(4'd1); exp_q.push_back(4'd3);
    end
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      tick();
      check("per_count", if0.dataOut, exp_v);
      check("per_done", if0.done, (exp_v == 3));
      check("per_expired", if0.expired, 0);
    end

    // Pause and priority
    set_ctrl(1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    set_ctrl(1'b0, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_ctrl(1'b0, 4'd6, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    check("pp_mid_count", if0.dataOut, 4);
    set_ctrl(1'b0, 4'd6, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    check("pp_stop_state", if0.state, S_PAUSE);
    check("pp_stop_busy", if0.busy, 1);
    set_ctrl(1'b0, 4'd6, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("pp_hold_count", if0.dataOut, 4);
    end
    set_ctrl(1'b0, 4'd6, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    check("pp_resume_count", if0.dataOut, 4);
    check("pp_resume_state", if0.state, S_RUN);
    set_ctrl(1'b0, 4'd6, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    check("pp_dec1", if0.dataOut, 3);
    tick();
    check("pp_dec2", if0.dataOut, 2);
    set_ctrl(1'b1, 4'd9, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    check("pp_load_count", if0.dataOut, 9);
    check("pp_load_state", if0.state, S_IDLE);
    check("pp_load_busy", if0.busy, 0);

    // STEP=2, COUNT_END=1 instance with gated enable
    set_ctrl(1'b1, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    set_ctrl(1'b0, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("st_start_count", if1.dataOut, 8);
    check("st_start_state", if1.state, S_RUN);
    for (int i = 0; i < 8; i++) begin
      set_ctrl(1'b0, 4'd8, 1'b0, 1'b0, en_pat[i], 1'b0);
      tick();
      check("st_count", if1.dataOut, cnt_pat[i]);
      check("st_done", if1.done, done_pat[i]);
    end
    check("st_expired", if1.expired, 1);

    // Load 0 with periodic: terminal on every enabled tick
    set_ctrl(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    set_ctrl(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    set_ctrl(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("z_count", if0.dataOut, 0);
      check("z_done", if0.done, 1);
      check("z_state", if0.state, S_RUN);
    end

    // Load all-ones one-shot: 15 ticks to expiry, no wrap
    set_ctrl(1'b1, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    set_ctrl(1'b0, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("max_start_count", if0.dataOut, 15);
    set_ctrl(1'b0, 4'd15, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int v = 14; v >= 0; v--) exp_q.push_back(DW'(v));
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      tick();
      check("max_count", if0.dataOut, exp_v);
      check("max_done", if0.done, (exp_v == 0));
      check("max_expired", if0.expired, (exp_v == 0));
    end
    tick();
    check("max_nowrap", if0.dataOut, 0);

    // Asynchronous reset mid-run at count 7
    set_ctrl(1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    set_ctrl(1'b0, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_ctrl(1'b0, 4'd9, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    check("ar_pre_count", if0.dataOut, 7);
    #1 rst = 1'b0;
    #1;
    check("ar_count",   if0.dataOut, 0);
    check("ar_busy",    if0.busy,    0);
    check("ar_done",    if0.done,    0);
    check("ar_expired", if0.expired, 0);
    set_ctrl(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b1;
    tick();
    check("ar_rel_count", if0.dataOut, 0);
    check("ar_rel_state", if0.state, S_IDLE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
